// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract sequencer.
//
// Unpacks the operands and orders them by magnitude. It aligns the smaller mantissa one bit per
// cycle and runs a 24-bit mantissa add/sub. It then normalizes, rounds to nearest-even and
// packs the result. Denormal inputs and denormal results are flushed to zero.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; aborts any operation in flight
//   start   launch an operation (sampled only while idle)
//   sub     0 = op_a + op_b, 1 = op_a - op_b
//   op_a    operand A
//   op_b    operand B
//   result  packed result, held until the next done
//   busy    high from the cycle after an accepted start until done
//   done    one-cycle pulse when result is valid
//   fflags  {NV,DZ,OF,UF,NX}; only present when FP_ADDSUB_SEQ_FLAGS_EN is defined
//
// Optional feature macro: FP_ADDSUB_SEQ_FLAGS_EN adds the fflags output and its flag logic.
module fp_addsub_seq #(
    parameter int unsigned MAX_ALIGN = 26,
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
    output logic [4:0]  fflags,
`endif
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] MaxAlign = 8'(MAX_ALIGN);

    typedef enum logic [2:0] {StIdle, StUnpack, StAlign, StAdd, StNorm, StRound, StPack} state_t;

    state_t      state;
    logic [31:0] a_q, b_q, spec_q;
    logic        sub_q, eop_q, sign_q, special_q;
    logic [9:0]  exp_q;
    logic [23:0] large_q;
    logic [26:0] small_q;    // {mantissa, guard, round, sticky}
    logic [7:0]  diff_q;
    logic [27:0] v_q;        // {carry, mantissa[23:0], guard, round, sticky}
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
    logic [4:0]  flg_q;
`endif

    // Operand decode; sign_b already carries the effective operation.
    logic        sign_a, sign_b, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, eop_c, swap_c;
    logic [7:0]  exp_a, exp_b, diff_c;
    logic [22:0] frac_a, frac_b;

    assign sign_a = a_q[31];
    assign sign_b = b_q[31] ^ sub_q;
    assign exp_a  = a_q[30:23];
    assign exp_b  = b_q[30:23];
    assign frac_a = a_q[22:0];
    assign frac_b = b_q[22:0];
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != '0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != '0);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == '0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == '0);
    assign zero_a = (exp_a == 8'h00);
    assign zero_b = (exp_b == 8'h00);
    assign eop_c  = sign_a ^ sign_b;
    assign swap_c = (exp_b > exp_a) || ((exp_b == exp_a) && (frac_b > frac_a));
    assign diff_c = swap_c ? (exp_b - exp_a) : (exp_a - exp_b);

`ifdef FP_ADDSUB_SEQ_FLAGS_EN
    logic snan_in;
    assign snan_in = (nan_a && !frac_a[22]) || (nan_b && !frac_b[22]);
`endif

    // Mantissa ALU; on subtract the small operand's G/R/S bits produce the borrow-in.
    logic        alu_borrow, alu_carry;
    logic [2:0]  grs_lo;
    logic [23:0] alu_result;

    always_comb begin
        alu_borrow = eop_q & (|small_q[2:0]);
        grs_lo     = eop_q ? (3'b000 - small_q[2:0]) : small_q[2:0];
        if (eop_q) begin
            {alu_carry, alu_result} = {1'b0, large_q} - {1'b0, small_q[26:3]} - 25'(alu_borrow);
        end else begin
            {alu_carry, alu_result} = {1'b0, large_q} + {1'b0, small_q[26:3]};
        end
    end

    // Round to nearest, ties to even.
    logic        round_up;
    logic [24:0] mant_inc;

    always_comb begin
        round_up = v_q[2] & (v_q[1] | v_q[0] | v_q[3]);
        mant_inc = {1'b0, v_q[26:3]} + 25'(round_up);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            spec_q    <= '0;
            sub_q     <= 1'b0;
            eop_q     <= 1'b0;
            sign_q    <= 1'b0;
            special_q <= 1'b0;
            exp_q     <= '0;
            large_q   <= '0;
            small_q   <= '0;
            diff_q    <= '0;
            v_q       <= '0;
            result    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
            flg_q     <= '0;
            fflags    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sub_q <= sub;
                        busy  <= 1'b1;
                        state <= StUnpack;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                        flg_q <= '0;
`endif
                    end
                end
                StUnpack: begin
                    special_q <= 1'b1;
                    state     <= StPack;
                    if (nan_a || nan_b) begin
                        spec_q <= CANON_NAN;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                        flg_q[4] <= snan_in;
`endif
                    end else if (inf_a && inf_b && eop_c) begin
                        spec_q <= CANON_NAN;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                        flg_q[4] <= 1'b1;
`endif
                    end else if (inf_a) begin
                        spec_q <= a_q;
                    end else if (inf_b) begin
                        spec_q <= {sign_b, 8'hFF, 23'h0};
                    end else if (zero_a && zero_b) begin
                        spec_q <= {sign_a & sign_b, 31'h0};
                    end else if (zero_a) begin
                        spec_q <= {sign_b, b_q[30:0]};
                    end else if (zero_b) begin
                        spec_q <= {sign_a, a_q[30:0]};
                    end else begin
                        special_q <= 1'b0;
                        eop_q     <= eop_c;
                        sign_q    <= swap_c ? sign_b : sign_a;
                        exp_q     <= {2'b00, swap_c ? exp_b : exp_a};
                        large_q   <= {1'b1, swap_c ? frac_b : frac_a};
                        small_q   <= {1'b1, swap_c ? frac_a : frac_b, 3'b000};
                        diff_q    <= diff_c;
                        state     <= (diff_c == 8'd0) ? StAdd : StAlign;
                    end
                end
                StAlign: begin
                    if (diff_q > MaxAlign) begin
                        // Too far below the LSB to matter except as sticky.
                        small_q <= 27'd1;
                        diff_q  <= '0;
                        state   <= StAdd;
                    end else begin
                        small_q <= {1'b0, small_q[26:2], small_q[1] | small_q[0]};
                        diff_q  <= diff_q - 8'd1;
                        if (diff_q == 8'd1) begin
                            state <= StAdd;
                        end
                    end
                end
                StAdd: begin
                    v_q   <= {alu_carry & ~eop_q, alu_result, grs_lo};
                    state <= StNorm;
                end
                StNorm: begin
                    if (v_q[27]) begin
                        v_q   <= {1'b0, v_q[27:2], v_q[1] | v_q[0]};
                        exp_q <= exp_q + 10'd1;
                        state <= StRound;
                    end else if (v_q[26:0] == '0) begin
                        special_q <= 1'b1;
                        spec_q    <= '0;
                        state     <= StPack;
                    end else if (v_q[26]) begin
                        state <= StRound;
                    end else if (exp_q <= 10'd1) begin
                        special_q <= 1'b1;
                        spec_q    <= '0;
                        state     <= StPack;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                        flg_q[1]  <= 1'b1;
                        flg_q[0]  <= 1'b1;
`endif
                    end else begin
                        v_q   <= {v_q[26:0], 1'b0};
                        exp_q <= exp_q - 10'd1;
                    end
                end
                StRound: begin
                    if (mant_inc[24]) begin
                        v_q   <= {1'b0, 24'h800000, 3'b000};
                        exp_q <= exp_q + 10'd1;
                    end else begin
                        v_q <= {1'b0, mant_inc[23:0], 3'b000};
                    end
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                    if (v_q[2:0] != 3'b000) begin
                        flg_q[0] <= 1'b1;
                    end
`endif
                    state <= StPack;
                end
                StPack: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                    fflags <= flg_q;
`endif
                    if (special_q) begin
                        result <= spec_q;
                    end else if (exp_q >= 10'd255) begin
                        result <= {sign_q, 8'hFF, 23'h0};
`ifdef FP_ADDSUB_SEQ_FLAGS_EN
                        fflags <= flg_q | 5'b00101;
`endif
                    end else begin
                        result <= {sign_q, exp_q[7:0], v_q[25:3]};
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
